// File: rtl/pb_nios_pkg.sv
// Shared definitions for the NIOS-to-packet-buffer word passer:
// FSM state encodings and bit positions of the NIOS handshake words.
package pb_nios_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ARM        = 4'd1,
    ST_REQ        = 4'd2,
    ST_WAIT_VALID = 4'd3,
    ST_WRITE      = 4'd4,
    ST_WAIT_DROP  = 4'd5,
    ST_ABORT      = 4'd6
  } state_t;

  localparam int DATA_LSB = 0;
  localparam int VALID    = 16;
  localparam int ACK      = 17;
  localparam int ABORTED  = 29;
  localparam int RDY      = 30;
  localparam int REQUEST  = 31;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;

endpackage

// File: rtl/nios_to_pb_passer.sv
// Moves WORDS 16-bit words from the NIOS four-phase handshake port into
// the packet buffer, one write pulse per word at consecutive addresses.
module nios_to_pb_passer
  import pb_nios_pkg::*;
#(
  parameter logic [ADDR_W-1:0] WORDS = 9'd256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              do_transfer,
  input  logic [31:0]       nios_packets_out_or_output_signals,
  output logic [31:0]       nios_packets_in_or_input_signals,
  output logic [ADDR_W-1:0] pb_address_proc_write,
  output logic [DATA_W-1:0] pb_data_proc_write,
  output logic              pb_wren_proc_write,
  output logic              transfered
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   count_q;
  logic                aborted_q;
  logic                rdy, valid, request, ack;
  logic [DATA_W-1:0]   word;
  logic                unused_in;

  assign rdy   = nios_packets_out_or_output_signals[RDY];
  assign valid = nios_packets_out_or_output_signals[VALID];
  assign word  = nios_packets_out_or_output_signals[DATA_LSB +: DATA_W];
  assign unused_in = ^{nios_packets_out_or_output_signals[31],
                       nios_packets_out_or_output_signals[29:17]};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge state.
    if (rst) begin
      state_q               <= ST_IDLE;
      count_q               <= '0;
      aborted_q             <= 1'b0;
      pb_address_proc_write <= '0;
      pb_data_proc_write    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE)  count_q <= '0;
      if (state_q == ST_WRITE) count_q <= count_q + 1'b1;
      if (state_q == ST_WAIT_VALID && state_d == ST_WRITE) begin
        pb_data_proc_write    <= word;
        pb_address_proc_write <= count_q;
      end
      // Aborted stays visible through IDLE so NIOS can read it; the next arm clears it.
      if (state_d == ST_ABORT)    aborted_q <= 1'b1;
      else if (state_d == ST_ARM) aborted_q <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    state_d            = state_q;
    pb_wren_proc_write = 1'b0;
    ack                = 1'b0;
    request            = 1'b0;
    transfered         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        transfered = 1'b1;
        if (do_transfer) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!do_transfer) state_d = ST_REQ;
      end
      ST_REQ: begin
        request = 1'b1;
        if (rdy) state_d = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        if (!rdy)       state_d = ST_ABORT;
        else if (valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        pb_wren_proc_write = 1'b1;
        ack                = 1'b1;
        state_d            = ST_WAIT_DROP;
      end
      ST_WAIT_DROP: begin
        // count_q already includes the word just written
        ack = 1'b1;
        if (!rdy)        state_d = ST_ABORT;
        else if (!valid) state_d = (count_q == WORDS) ? ST_IDLE : ST_WAIT_VALID;
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    nios_packets_in_or_input_signals          = '0;
    nios_packets_in_or_input_signals[REQUEST] = request;
    nios_packets_in_or_input_signals[ACK]     = ack;
    nios_packets_in_or_input_signals[ABORTED] = aborted_q;
  end

endmodule

// File: tb/tb_nios_to_pb_passer.sv
// Randomized bench: a 256-word passer and a 4-word passer share one NIOS
// stimulus; observed buffer writes are compared against the expected word stream.
module tb_nios_to_pb_passer;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_transfer;
  logic [31:0] from_nios;
  logic [31:0] to_nios,   to_nios4;
  logic [8:0]  pb_addr,   pb_addr4;
  logic [15:0] pb_data,   pb_data4;
  logic        pb_wren,   pb_wren4;
  logic        done,      done4;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed packet-buffer writes, in order, per DUT
  int          wcount  = 0;
  int          wcount4 = 0;
  logic [8:0]  wr_addr  [512];
  logic [15:0] wr_data  [512];
  logic [8:0]  wr_addr4 [8];
  logic [15:0] wr_data4 [8];

  logic [15:0] sent [$];

  always #5 clk = ~clk;

  nios_to_pb_passer #(.WORDS(9'd256)) u_dut (
    .clk(clk), .rst(rst), .do_transfer(do_transfer),
    .nios_packets_out_or_output_signals(from_nios),
    .nios_packets_in_or_input_signals(to_nios),
    .pb_address_proc_write(pb_addr), .pb_data_proc_write(pb_data),
    .pb_wren_proc_write(pb_wren), .transfered(done)
  );

  nios_to_pb_passer #(.WORDS(9'd4)) u_dut4 (
    .clk(clk), .rst(rst), .do_transfer(do_transfer),
    .nios_packets_out_or_output_signals(from_nios),
    .nios_packets_in_or_input_signals(to_nios4),
    .pb_address_proc_write(pb_addr4), .pb_data_proc_write(pb_data4),
    .pb_wren_proc_write(pb_wren4), .transfered(done4)
  );

  always @(negedge clk) begin
    if (pb_wren) begin
      if (wcount < 512) begin
        wr_addr[wcount] = pb_addr;
        wr_data[wcount] = pb_data;
      end
      wcount++;
    end
    if (pb_wren4) begin
      if (wcount4 < 8) begin
        wr_addr4[wcount4] = pb_addr4;
        wr_data4[wcount4] = pb_data4;
      end
      wcount4++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    do_transfer = 1'b0;
    from_nios = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // NIOS side of one four-phase word; NIOS follows the 256-word DUT's ack.
  task automatic send_word(input logic [15:0] d, input bit noise);
    bit seen;
    do_transfer = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    from_nios[15:0] = d;
    from_nios[16]   = 1'b1;
    sent.push_back(d);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = to_nios[17];
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL ack_rise: no ack within 10 cycles for word %0h", d); end
    repeat ($urandom_range(0, 2)) tick();
    from_nios[16] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = !to_nios[17];
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL ack_fall: ack still high 10 cycles after valid dropped"); end
  endtask

  task automatic start_transfer();
    bit seen;
    from_nios       = '0;
    from_nios[29:17] = 13'($urandom);
    from_nios[31]    = 1'($urandom);
    do_transfer = 1'b1;
    tick();
    do_transfer = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = to_nios[31];
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL request: got no request within 10 cycles, want request=1"); end
    from_nios[30] = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if (to_nios !== 32'h0) begin n_fail++; $display("FAIL reset_nios_in: got %h want 00000000", to_nios); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL reset_transfered: got %b want 1", done); end
    n_checks++;
    if ({pb_wren, pb_addr, pb_data} !== 26'h0) begin
      n_fail++; $display("FAIL reset_pb: got wren=%b addr=%0h data=%h want 0/0/0", pb_wren, pb_addr, pb_data);
    end
    n_checks++;
    if (done4 !== 1'b1) begin n_fail++; $display("FAIL reset_transfered4: got %b want 1", done4); end
  endtask

  task automatic test_handshake();
    wcount = 0; wcount4 = 0; sent.delete();
    from_nios = '0;
    from_nios[29:17] = 13'($urandom);
    do_transfer = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b0 || to_nios !== 32'h0) begin
      n_fail++; $display("FAIL arm: got transfered=%b nios_in=%h want 0/00000000", done, to_nios);
    end
    do_transfer = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (to_nios !== 32'h8000_0000) begin n_fail++; $display("FAIL req_hold: got %h want 80000000", to_nios); end
    from_nios[30] = 1'b1;
    tick();
    n_checks++;
    if (to_nios[31] !== 1'b0) begin n_fail++; $display("FAIL req_drop: got %b want 0", to_nios[31]); end
    from_nios[15:0] = 16'hBEEF;
    from_nios[16]   = 1'b1;
    sent.push_back(16'hBEEF);
    tick();
    n_checks++;
    if ({pb_wren, to_nios[17], pb_addr, pb_data} !== {1'b1, 1'b1, 9'd0, 16'hBEEF}) begin
      n_fail++; $display("FAIL first_write: got wren=%b ack=%b addr=%0h data=%h want 1/1/0/beef",
                         pb_wren, to_nios[17], pb_addr, pb_data);
    end
    repeat (2) tick();
    n_checks++;
    if (pb_wren !== 1'b0 || to_nios[17] !== 1'b1) begin
      n_fail++; $display("FAIL ack_hold: got wren=%b ack=%b want 0/1", pb_wren, to_nios[17]);
    end
    from_nios[16] = 1'b0;
    tick();
    n_checks++;
    if (to_nios[17] !== 1'b0) begin n_fail++; $display("FAIL ack_release: got %b want 0", to_nios[17]); end
  endtask

  task automatic test_held_valid();
    int ack_cycles = 0;
    logic [15:0] d;
    d = 16'($urandom);
    from_nios[15:0] = d;
    from_nios[16]   = 1'b1;
    sent.push_back(d);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (to_nios[17]) ack_cycles++;
    end
    n_checks++;
    if (ack_cycles != 10) begin n_fail++; $display("FAIL held_ack: got %0d ack cycles want 10", ack_cycles); end
    n_checks++;
    if (wcount != 2) begin n_fail++; $display("FAIL held_writes: got %0d writes want 2", wcount); end
    from_nios[16] = 1'b0;
    tick();
  endtask

  task automatic test_words4();
    send_word(16'($urandom), 1'b0);
    send_word(16'($urandom), 1'b0);
    n_checks++;
    if (done4 !== 1'b1) begin n_fail++; $display("FAIL w4_done: got transfered=%b want 1", done4); end
    send_word(16'($urandom), 1'b0);
    n_checks++;
    if (wcount4 != 4) begin n_fail++; $display("FAIL w4_count: got %0d writes want 4", wcount4); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_addr4[i] !== 9'(i) || wr_data4[i] !== sent[i]) begin
        n_fail++; $display("FAIL w4_word%0d: got %0h/%h want %0h/%h", i, wr_addr4[i], wr_data4[i], i, sent[i]);
      end
    end
  endtask

  task automatic test_abort();
    from_nios[30] = 1'b0;
    tick();
    n_checks++;
    if ({to_nios[29], to_nios[17], pb_wren, done} !== 4'b1000) begin
      n_fail++; $display("FAIL abort_state: got aborted=%b ack=%b wren=%b transfered=%b want 1/0/0/0",
                         to_nios[29], to_nios[17], pb_wren, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || to_nios !== 32'h2000_0000) begin
      n_fail++; $display("FAIL abort_idle: got transfered=%b nios_in=%h want 1/20000000", done, to_nios);
    end
    from_nios[16] = 1'b1;
    repeat (3) tick();
    from_nios[16] = 1'b0;
    tick();
    n_checks++;
    if (wcount != 5) begin n_fail++; $display("FAIL abort_writes: got %0d writes want 5", wcount); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (wr_addr[i] !== 9'(i) || wr_data[i] !== sent[i]) begin
        n_fail++; $display("FAIL abort_word%0d: got %0h/%h want %0h/%h", i, wr_addr[i], wr_data[i], i, sent[i]);
      end
    end
  endtask

  task automatic test_full_transfer();
    int bad = 0;
    wcount = 0; sent.delete();
    do_transfer = 1'b1;
    tick();
    n_checks++;
    if (to_nios[29] !== 1'b0) begin n_fail++; $display("FAIL arm_clears_abort: got %b want 0", to_nios[29]); end
    do_transfer = 1'b0;
    tick();
    from_nios[30] = 1'b1;
    tick();
    for (int n = 0; n < 256; n++) send_word(16'(n), n < 255);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got transfered=%b want 1", done); end
    n_checks++;
    if (wcount != 256) begin n_fail++; $display("FAIL full_count: got %0d writes want 256", wcount); end
    for (int n = 0; n < 256; n++)
      if (wr_addr[n] !== 9'(n) || wr_data[n] !== 16'(n)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL full_words: got %0d wrong words want 0", bad); end
  endtask

  task automatic test_reset_mid();
    wcount = 0; sent.delete();
    start_transfer();
    for (int n = 0; n < 100; n++) send_word(16'($urandom), 1'b0);
    from_nios[15:0] = 16'h1234;
    from_nios[16]   = 1'b1;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({to_nios, pb_wren, done, pb_addr, pb_data} !== {32'h0, 1'b0, 1'b1, 9'h0, 16'h0}) begin
      n_fail++; $display("FAIL mid_reset: got nios_in=%h wren=%b transfered=%b addr=%0h data=%h want 0/0/1/0/0",
                         to_nios, pb_wren, done, pb_addr, pb_data);
    end
    @(negedge clk); #1;
    n_checks++;
    if (wcount != 100) begin n_fail++; $display("FAIL mid_no_partial: got %0d writes want 100", wcount); end
    rst = 1'b0;
    from_nios = '0;
    tick();
    wcount = 0; sent.delete();
    start_transfer();
    for (int n = 0; n < 3; n++) send_word(16'($urandom), 1'b0);
    n_checks++;
    if (wcount != 3) begin n_fail++; $display("FAIL restart_count: got %0d writes want 3", wcount); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_addr[i] !== 9'(i) || wr_data[i] !== sent[i]) begin
        n_fail++; $display("FAIL restart_word%0d: got %0h/%h want %0h/%h", i, wr_addr[i], wr_data[i], i, sent[i]);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_handshake();
    test_held_valid();
    test_words4();
    test_abort();
    test_full_transfer();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
